// File: rtl/regfile_pkg.sv
// Shared defaults for the scoreboarded register file.
// Width and index constants used by the top, interface and scoreboard.
package regfile_pkg;

  localparam int DEF_DATA_W      = 32;
  localparam int DEF_ADDR_W      = 5;
  localparam int DEF_NUM_RD      = 2;
  localparam int DEF_TAG_W       = 4;
  localparam int DEF_ARG_W       = 6;
  localparam int DEF_TEST_LO     = 12;
  localparam int DEF_TEST_HI     = 13;
  localparam int REG_ZERO        = 0;
  localparam int DEF_PRELOAD_REG = 24;

endpackage

// File: rtl/regfile_sb_if.sv
// Issue / CDB / read-port bundle between the pipeline and regfile_sb.
// master drives requests, slave returns read data and scoreboard state.
interface regfile_sb_if
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NUM_RD = DEF_NUM_RD,
  parameter int TAG_W  = DEF_TAG_W
);

  logic [NUM_RD*ADDR_W-1:0] raddr;
  logic [NUM_RD*DATA_W-1:0] rdata;
  logic [NUM_RD-1:0]        rbusy;
  logic [NUM_RD*TAG_W-1:0]  rtag;

  logic              rsv_en;
  logic [ADDR_W-1:0] rsv_addr;
  logic [TAG_W-1:0]  rsv_tag;

  logic              wb_en;
  logic [TAG_W-1:0]  wb_tag;
  logic [DATA_W-1:0] wb_data;

  logic              flush;

  modport master (
    output raddr,
    output rsv_en, rsv_addr, rsv_tag,
    output wb_en, wb_tag, wb_data,
    output flush,
    input  rdata, rbusy, rtag
  );

  modport slave (
    input  raddr,
    input  rsv_en, rsv_addr, rsv_tag,
    input  wb_en, wb_tag, wb_data,
    input  flush,
    output rdata, rbusy, rtag
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// Busy/tag scoreboard: tag match against the CDB, reserve, flush
// and a busy counter kept equal to the popcount of the busy vector.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter  int ADDR_W = DEF_ADDR_W,
  parameter  int TAG_W  = DEF_TAG_W,
  localparam int DEPTH  = 2**ADDR_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rsv_en_i,
  input  logic [ADDR_W-1:0]           rsv_addr_i,
  input  logic [TAG_W-1:0]            rsv_tag_i,
  input  logic                        wb_en_i,
  input  logic [TAG_W-1:0]            wb_tag_i,
  input  logic                        flush_i,
  output logic [DEPTH-1:0]            busy_o,
  output logic [DEPTH-1:0][TAG_W-1:0] tag_o,
  output logic [DEPTH-1:0]            we_o,
  output logic [ADDR_W:0]             busy_cnt_o
);

  logic [DEPTH-1:0]            busy_q, busy_d;
  logic [DEPTH-1:0][TAG_W-1:0] tag_q, tag_d;
  logic [DEPTH-1:0]            match;
  logic [DEPTH-1:0]            rsv_hit;
  logic [ADDR_W:0]             cnt_q, cnt_d;

  always_comb begin
    match   = '0;
    rsv_hit = '0;
    for (int r = 0; r < DEPTH; r++) begin
      match[r] = wb_en_i && busy_q[r]
              && (tag_q[r] == wb_tag_i);
      rsv_hit[r] = rsv_en_i && !flush_i
                && (rsv_addr_i == ADDR_W'(r))
                && (r != REG_ZERO);
    end
  end

  // Reserve overrides a same-cycle match; flush overrides both.
  always_comb begin
    busy_d = busy_q;
    tag_d  = tag_q;
    for (int r = 0; r < DEPTH; r++) begin
      if (rsv_hit[r]) begin
        busy_d[r] = 1'b1;
        tag_d[r]  = rsv_tag_i;
      end else if (match[r]) begin
        busy_d[r] = 1'b0;
        tag_d[r]  = '0;
      end
    end
    if (flush_i) begin
      busy_d = '0;
      tag_d  = '0;
    end
  end

  always_comb begin
    cnt_d = '0;
    for (int r = 0; r < DEPTH; r++) begin
      cnt_d = cnt_d + {{ADDR_W{1'b0}}, busy_d[r]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
      tag_q  <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      tag_q  <= tag_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy_o     = busy_q;
  assign tag_o      = tag_q;
  assign we_o       = match;
  assign busy_cnt_o = cnt_q;

endmodule

// File: rtl/regfile_sb.sv
// Register file with per-register scoreboard, CDB bypass on reads,
// switch preload at reset and a debug test_result tap.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int NUM_RD      = DEF_NUM_RD,
  parameter int TAG_W       = DEF_TAG_W,
  parameter int PRELOAD_REG = DEF_PRELOAD_REG,
  parameter int ARG_W       = DEF_ARG_W,
  parameter int TEST_LO     = DEF_TEST_LO,
  parameter int TEST_HI     = DEF_TEST_HI
) (
  input  logic               clk,
  input  logic               rst,
  regfile_sb_if.slave        bus,
  input  logic [ARG_W-1:0]   arguments,
  output logic [ADDR_W:0]    busy_cnt,
  output logic [DATA_W+3:0]  test_result
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DEPTH-1:0][DATA_W-1:0] regs_q, regs_d;
  logic [DEPTH-1:0]             busy;
  logic [DEPTH-1:0][TAG_W-1:0]  tag;
  logic [DEPTH-1:0]             we;

  regfile_scoreboard #(
    .ADDR_W (ADDR_W),
    .TAG_W  (TAG_W)
  ) u_sb (
    .clk        (clk),
    .rst        (rst),
    .rsv_en_i   (bus.rsv_en),
    .rsv_addr_i (bus.rsv_addr),
    .rsv_tag_i  (bus.rsv_tag),
    .wb_en_i    (bus.wb_en),
    .wb_tag_i   (bus.wb_tag),
    .flush_i    (bus.flush),
    .busy_o     (busy),
    .tag_o      (tag),
    .we_o       (we),
    .busy_cnt_o (busy_cnt)
  );

  always_comb begin
    regs_d = regs_q;
    for (int r = 0; r < DEPTH; r++) begin
      if (we[r]) regs_d[r] = bus.wb_data;
    end
    regs_d[REG_ZERO] = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs_q              <= '0;
      regs_q[PRELOAD_REG] <= DATA_W'(arguments);
    end else begin
      regs_q <= regs_d;
    end
  end

  // Bypass is the same match that commits; a flush voids it.
  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic              byp;

    assign a   = bus.raddr[i*ADDR_W +: ADDR_W];
    assign byp = we[a] && !bus.flush;

    assign bus.rdata[i*DATA_W +: DATA_W] =
      byp ? bus.wb_data : regs_q[a];
    assign bus.rbusy[i] = byp ? 1'b0 : busy[a];
    assign bus.rtag[i*TAG_W +: TAG_W] =
      byp ? '0 : tag[a];
  end

  assign test_result = {regs_q[TEST_HI][3:0], regs_q[TEST_LO]};

endmodule

// File: tb/tb_regfile_sb.sv
// Directed plus randomized bench for regfile_sb against an
// array-based reference model of the register file and scoreboard.
module tb_regfile_sb;

  logic        clk;
  logic        rst;
  logic [5:0]  arguments;
  logic [5:0]  busy_cnt;
  logic [35:0] test_result;

  regfile_sb_if bus ();

  regfile_sb dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus.slave),
    .arguments   (arguments),
    .busy_cnt    (busy_cnt),
    .test_result (test_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] m_data [32];
  bit          m_busy [32];
  logic [3:0]  m_tag  [32];
  int          ra     [2];

  task automatic chk(input string name, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", name, got, exp);
    end
  endtask

  task automatic m_reset(input logic [5:0] args);
    for (int r = 0; r < 32; r++) begin
      m_data[r] = '0;
      m_busy[r] = 1'b0;
      m_tag[r]  = '0;
    end
    m_data[24] = {26'd0, args};
  endtask

  function automatic int m_cnt();
    int c = 0;
    for (int r = 0; r < 32; r++) c += int'(m_busy[r]);
    return c;
  endfunction

  // Commit state for the edge about to happen from current inputs.
  task automatic m_apply();
    bit hit [32];
    for (int r = 0; r < 32; r++)
      hit[r] = bus.wb_en && m_busy[r] && (m_tag[r] == bus.wb_tag);
    for (int r = 0; r < 32; r++) begin
      if (hit[r]) begin
        m_data[r] = bus.wb_data;
        m_busy[r] = 1'b0;
        m_tag[r]  = '0;
      end
    end
    if (bus.flush) begin
      for (int r = 0; r < 32; r++) begin
        m_busy[r] = 1'b0;
        m_tag[r]  = '0;
      end
    end else if (bus.rsv_en && bus.rsv_addr != 0) begin
      m_busy[bus.rsv_addr] = 1'b1;
      m_tag[bus.rsv_addr]  = bus.rsv_tag;
    end
  endtask

  task automatic check_outputs();
    for (int i = 0; i < 2; i++) begin
      int a;
      logic [31:0] ed;
      logic        eb;
      logic [3:0]  et;
      a = ra[i];
      if (bus.wb_en && !bus.flush && m_busy[a]
          && m_tag[a] == bus.wb_tag) begin
        ed = bus.wb_data; eb = 1'b0; et = '0;
      end else begin
        ed = m_data[a]; eb = m_busy[a];
        et = m_busy[a] ? m_tag[a] : 4'd0;
      end
      chk($sformatf("rdata%0d[r%0d]", i, a),
          64'(bus.rdata[i*32 +: 32]), 64'(ed));
      chk($sformatf("rbusy%0d[r%0d]", i, a),
          64'(bus.rbusy[i]), 64'(eb));
      chk($sformatf("rtag%0d[r%0d]", i, a),
          64'(bus.rtag[i*4 +: 4]), 64'(et));
    end
    chk("test_result", 64'(test_result),
        64'({m_data[13][3:0], m_data[12]}));
  endtask

  task automatic drive(input bit re, input int rad, input int rtg,
                       input bit we, input int wtg,
                       input logic [31:0] wd, input bit fl,
                       input int a0, input int a1);
    bus.rsv_en   = re;
    bus.rsv_addr = 5'(rad);
    bus.rsv_tag  = 4'(rtg);
    bus.wb_en    = we;
    bus.wb_tag   = 4'(wtg);
    bus.wb_data  = wd;
    bus.flush    = fl;
    ra[0]        = a0;
    ra[1]        = a1;
    bus.raddr    = {5'(a1), 5'(a0)};
  endtask

  task automatic idle(input int a0, input int a1);
    drive(0, 0, 0, 0, 0, 32'h0, 0, a0, a1);
  endtask

  task automatic settle();
    #1;
    check_outputs();
  endtask

  task automatic edge_step();
    m_apply();
    @(posedge clk);
    #1;
    chk("busy_cnt", 64'(busy_cnt), 64'(m_cnt()));
  endtask

  task automatic step(input bit re, input int rad, input int rtg,
                      input bit we, input int wtg,
                      input logic [31:0] wd, input bit fl,
                      input int a0, input int a1);
    drive(re, rad, rtg, we, wtg, wd, fl, a0, a1);
    settle();
    edge_step();
  endtask

  function automatic logic [31:0] rdat(input int i);
    return bus.rdata[i*32 +: 32];
  endfunction

  initial begin
    rst       = 1'b1;
    arguments = 6'h2D;
    idle(24, 0);
    m_reset(6'h2D);
    #3;
    chk("busy_cnt_in_reset", 64'(busy_cnt), 64'd0);
    #9;
    rst = 1'b0;
    @(posedge clk);
    #1;

    idle(24, 0);
    settle();
    chk("preload_r24", 64'(rdat(0)), 64'h2D);
    chk("r0_zero", 64'(rdat(1)), 64'h0);
    chk("busy_cnt_reset", 64'(busy_cnt), 64'd0);
    edge_step();

    step(1, 5, 3, 0, 0, 0, 0, 5, 0);
    idle(5, 0);
    settle();
    chk("r5_busy", 64'(bus.rbusy[0]), 64'd1);
    chk("r5_tag", 64'(bus.rtag[3:0]), 64'd3);
    chk("cnt_after_rsv", 64'(busy_cnt), 64'd1);
    edge_step();
    drive(0, 0, 0, 1, 3, 32'hCAFE_0001, 0, 5, 0);
    settle();
    chk("r5_bypass_data", 64'(rdat(0)), 64'hCAFE_0001);
    chk("r5_bypass_busy", 64'(bus.rbusy[0]), 64'd0);
    edge_step();
    idle(5, 0);
    settle();
    chk("r5_commit", 64'(rdat(0)), 64'hCAFE_0001);
    chk("cnt_after_wb", 64'(busy_cnt), 64'd0);
    edge_step();

    step(1, 7, 1, 0, 0, 0, 0, 7, 0);
    step(1, 7, 2, 0, 0, 0, 0, 7, 0);
    step(0, 0, 0, 1, 1, 32'h11, 0, 7, 0);
    idle(7, 0);
    settle();
    chk("waw_r7_data", 64'(rdat(0)), 64'h0);
    chk("waw_r7_busy", 64'(bus.rbusy[0]), 64'd1);
    chk("waw_r7_tag", 64'(bus.rtag[3:0]), 64'd2);
    edge_step();
    step(0, 0, 0, 1, 2, 32'h22, 0, 7, 0);
    idle(7, 0);
    settle();
    chk("waw_r7_final", 64'(rdat(0)), 64'h22);
    chk("waw_cnt", 64'(busy_cnt), 64'd0);
    edge_step();

    step(1, 9, 4, 0, 0, 0, 0, 9, 0);
    step(1, 9, 5, 1, 4, 32'h44, 0, 9, 0);
    idle(9, 0);
    settle();
    chk("same_r9_data", 64'(rdat(0)), 64'h44);
    chk("same_r9_busy", 64'(bus.rbusy[0]), 64'd1);
    chk("same_r9_tag", 64'(bus.rtag[3:0]), 64'd5);
    chk("same_cnt", 64'(busy_cnt), 64'd1);
    edge_step();
    step(0, 0, 0, 1, 5, 32'h55, 0, 9, 0);

    step(1, 1, 6, 0, 0, 0, 0, 1, 2);
    step(1, 2, 7, 0, 0, 0, 0, 1, 2);
    step(1, 3, 8, 0, 0, 0, 0, 3, 2);
    chk("cnt_three", 64'(busy_cnt), 64'd3);
    drive(1, 4, 9, 1, 7, 32'hBB, 1, 2, 1);
    settle();
    chk("flush_no_bypass", 64'(bus.rbusy[0]), 64'd1);
    edge_step();
    idle(2, 4);
    settle();
    chk("flush_r2_data", 64'(rdat(0)), 64'hBB);
    chk("flush_r2_busy", 64'(bus.rbusy[0]), 64'd0);
    chk("flush_r4_ignored", 64'(bus.rbusy[1]), 64'd0);
    chk("flush_cnt", 64'(busy_cnt), 64'd0);
    edge_step();

    step(1, 12, 9, 0, 0, 0, 0, 12, 13);
    step(0, 0, 0, 1, 9, 32'h1234_5678, 0, 12, 13);
    step(1, 13, 10, 0, 0, 0, 0, 12, 13);
    step(0, 0, 0, 1, 10, 32'hF, 0, 12, 13);
    chk("test_result_tap", 64'(test_result), 64'hF_1234_5678);

    step(1, 4, 11, 0, 0, 0, 0, 4, 24);
    idle(4, 24);
    #2;
    chk("r4_busy_pre_rst", 64'(bus.rbusy[0]), 64'd1);
    arguments = 6'h3A;
    rst = 1'b1;
    #1;
    m_reset(6'h3A);
    check_outputs();
    chk("async_cnt", 64'(busy_cnt), 64'd0);
    chk("async_r4_busy", 64'(bus.rbusy[0]), 64'd0);
    chk("async_r24", 64'(rdat(1)), 64'h3A);
    chk("async_tap", 64'(test_result), 64'h0);
    #3;
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int k = 0; k < 400; k++) begin
      int pr, a0;
      logic [3:0] wt;
      pr = $urandom_range(1, 31);
      wt = ($urandom_range(0, 3) != 0) ? m_tag[pr]
                                        : 4'($urandom_range(0, 15));
      a0 = ($urandom_range(0, 1) != 0) ? pr : $urandom_range(0, 31);
      step($urandom_range(0, 9) < 6, $urandom_range(0, 31),
           $urandom_range(0, 7), $urandom_range(0, 1) != 0,
           int'(wt), $urandom, $urandom_range(0, 19) == 0,
           a0, $urandom_range(0, 31));
    end

    for (int k = 0; k < 16; k++) begin
      idle(2 * k, 2 * k + 1);
      settle();
      edge_step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised register file with an integrated per-register scoreboard (busy bit + producer tag) for the dynamic-issue pipeline.
- The issue stage reserves a destination register against a tag. The common-data-bus writeback commits data only when its tag matches the register's current tag.
- Read ports return the value, busy flag and tag, with same-cycle writeback bypass.
- Keeps switch preload at reset and the debug test_result tap.

Parameters:
- DATA_W, 32, register data width
- ADDR_W, 5, register address width; depth = 2**ADDR_W
- NUM_RD, 2, number of read ports
- TAG_W, 4, producer tag width
- PRELOAD_REG, 24, register loaded from arguments at reset
- ARG_W, 6, width of arguments
- TEST_LO, 12, register supplying test_result[DATA_W-1:0]
- TEST_HI, 13, register supplying test_result[DATA_W+3:DATA_W]

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- raddr  in  NUM_RD*ADDR_W  read addresses; port i occupies [i*ADDR_W +: ADDR_W]
- rdata  out  NUM_RD*DATA_W  read data per port
- rbusy  out  NUM_RD  register awaiting producer, per port
- rtag  out  NUM_RD*TAG_W  pending producer tag per port; 0 when not busy
- rsv_en  in  1  reserve request from issue
- rsv_addr  in  ADDR_W  destination register to reserve
- rsv_tag  in  TAG_W  tag of the issuing instruction
- wb_en  in  1  CDB writeback valid
- wb_tag  in  TAG_W  CDB producer tag
- wb_data  in  DATA_W  CDB result
- flush  in  1  clear all busy bits (mispredict/exception)
- arguments  in  ARG_W  switch value preloaded at reset
- busy_cnt  out  ADDR_W+1  number of currently busy registers
- test_result  out  DATA_W+4  {reg[TEST_HI][3:0], reg[TEST_LO]}

Behaviour:
- Reset (async): all registers = 0, except reg[PRELOAD_REG] = zero-extended arguments. All busy = 0, all tags = 0, busy_cnt = 0. Reset asserted mid-operation discards all reservations immediately.
- Register 0:
  - Reads return data 0, busy 0, tag 0.
  - rsv_en with rsv_addr = 0 is ignored.
  - Register 0 is never written.
- Reserve (posedge, rsv_en=1, rsv_addr != 0): busy[rsv_addr] <= 1 and tag[rsv_addr] <= rsv_tag. Re-reserving an already-busy register overwrites the tag; the older producer's writeback is then dropped (WAW).
- Writeback (posedge, wb_en=1): every register r with busy[r]=1 and tag[r]==wb_tag gets reg[r] <= wb_data and busy[r] <= 0. No match means no state change. More than one match is legal and all matching registers are updated.
- Same register reserved and matched by writeback in one cycle:
  - data is written;
  - busy stays 1;
  - tag takes rsv_tag (reserve wins scoreboard state).
- Flush (posedge): all busy <= 0, tags <= 0; register data is retained. A writeback in the same cycle still commits to matching registers first, evaluated against pre-flush state. A same-cycle reserve is ignored (flush wins).
- Reads are combinational. When port i addresses a busy register whose tag equals wb_tag with wb_en=1 in the same cycle:
  - rdata = wb_data, rbusy = 0, rtag = 0.
  - Bypass is suppressed if flush=1 is also asserted.
- busy_cnt is a registered count updated each cycle:
  - +1 when a reserve sets a non-busy register busy;
  - -1 per register cleared by writeback;
  - forced to 0 on flush.
  - It must equal the popcount of busy after every edge.
- test_result is combinational from register contents and reflects committed data only (no bypass).
- No handshake backpressure: the issue stage must not present rsv_en when tags are exhausted. The block does not check tag uniqueness.

Decomposition:
- Shared package regfile_pkg holds DATA_W, ADDR_W, TAG_W and NUM_RD defaults, REG_ZERO = 0, and PRELOAD_REG.
- One sub-module, regfile_scoreboard, owns the busy/tag arrays, the match vector, flush and busy_cnt. It outputs a per-register write-enable vector to the data array.
- The top level owns the data array, preload, read muxes and bypass.

Test Plan:
- Reset with arguments=6'h2D, then read port 0 from reg 24 -> rdata=32'h2D, rbusy=0; read reg 0 -> 0; busy_cnt=0.
- Reserve r5 with tag 3; next cycle read r5 -> rbusy=1, rtag=3, busy_cnt=1. Writeback tag 3 with data 32'hCAFE_0001 in a later cycle -> that same cycle r5 reads 32'hCAFE_0001 with rbusy=0 via bypass; next cycle committed with busy_cnt=0.
- WAW: reserve r7 with tag 1, then r7 with tag 2. Writeback tag 1 with data 32'h11 -> r7 unchanged and busy with tag 2. Writeback tag 2 with data 32'h22 -> r7=32'h22, busy_cnt=0.
- Same cycle: r9 busy with tag 4, then wb tag 4 (data 32'h44) together with rsv r9 tag 5 -> r9 data=32'h44, busy=1, tag=5, busy_cnt unchanged at 1.
- Reserve r1, r2, r3 (busy_cnt=3), then flush together with wb matching r2 (data 32'hBB) -> r2=32'hBB, all busy=0, busy_cnt=0. Then write reg12=32'h12345678 and reg13=32'hF via reserve+wb -> test_result=36'hF_1234_5678.
- Assert rst asynchronously mid-cycle while r4 is busy -> busy, busy_cnt and the registers clear immediately without a clock edge. reg24 reloads from arguments.
